mseq_prn_gen: RTL

Upstream PRN source for the PRN-times-K / DDS modulation stage. Generates a maximal-length m-sequence with a Galois LFSR and steps it at a programmable chip rate. Presents the full LFSR state as an unsigned 16-bit PRN word on MSEQ_signal, which holds between updates. Run control is start/stop, continuous or one-shot, with a period-complete pulse.

---
 rtl/mseq_pkg.sv | 15 +
 rtl/mseq_lfsr_step.sv | 15 +
 rtl/mseq_prn_gen.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mseq_pkg.sv
// mseq_pkg: shared types and defaults for the m-sequence PRN source.
// Galois LFSR width, feedback mask, divider width, period length.
package mseq_pkg;

  localparam int MSEQ_W = 16;
  localparam logic [15:0] MSEQ_TAPS = 16'hB400;
  localparam int MSEQ_DIV_W = 16;
  localparam int MSEQ_PERIOD = (1 << MSEQ_W) - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mseq_state_e;

endpackage

// File: rtl/mseq_lfsr_step.sv
// mseq_lfsr_step: one right-shifting Galois LFSR step.
// Pure combinational; width and feedback mask are parameters.
module mseq_lfsr_step
  import mseq_pkg::*;
#(
  parameter int W = MSEQ_W,
  parameter logic [W-1:0] LFSR_TAPS = MSEQ_TAPS
) (
  input  logic [W-1:0] cur,
  output logic [W-1:0] nxt
);

  assign nxt = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);

endmodule

// File: rtl/mseq_prn_gen.sv
// mseq_prn_gen: Galois m-sequence PRN source with chip-rate divider.
// Optional all-zero lockup recovery: define MSEQ_LOCKUP_CHK_EN.
module mseq_prn_gen
  import mseq_pkg::*;
#(
  parameter int OUTPUT_DATA_WIDTH = MSEQ_W,
  parameter logic [OUTPUT_DATA_WIDTH-1:0] LFSR_TAPS = MSEQ_TAPS,
  parameter int DIV_WIDTH = MSEQ_DIV_W
) (
  input  logic                         MSEQ_clk,
  input  logic                         MSEQ_rst_n,
  input  logic                         mseq_start,
  input  logic                         mseq_stop,
  input  logic                         one_shot,
  input  logic [OUTPUT_DATA_WIDTH-1:0] seed,
  input  logic [DIV_WIDTH-1:0]         chip_div,
  output logic [OUTPUT_DATA_WIDTH-1:0] MSEQ_signal,
  output logic                         MSEQ_valid,
  output logic                         period_done,
  output logic                         busy,
  output logic                         lockup_err
);

  localparam int W = OUTPUT_DATA_WIDTH;
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};

  mseq_state_e state;
  mseq_state_e state_nx;

  logic [W-1:0] lfsr;
  logic [W-1:0] lfsr_nx;
  logic [W-1:0] chip_cnt;
  logic [W-1:0] seed_eff;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] div_q;
  logic os_q;
  logic go;
  logic reload;
  logic chip;
  logic wrap;
  logic halt;

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  assign seed_eff = (seed == '0) ? ONE : seed;
  assign busy = (state == RUN);

  mseq_lfsr_step #(
    .W(W),
    .LFSR_TAPS(LFSR_TAPS)
  ) u_step (
    .cur(lfsr),
    .nxt(lfsr_nx)
  );

`ifdef MSEQ_LOCKUP_CHK_EN
  logic lock_q;

  assign reload = busy && !mseq_stop && (lfsr == '0);
  assign lockup_err = lock_q;

  // Sticky lockup flag: set on recovery, cleared by a new start.
  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) begin
      lock_q <= 1'b0;
    end else if (go) begin
      lock_q <= 1'b0;
    end else if (reload) begin
      lock_q <= 1'b1;
    end
  end
`else
  assign reload = 1'b0;
  assign lockup_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state plus start / chip-step / period-end decode.
  always_comb begin
    state_nx = state;
    go = 1'b0;
    chip = 1'b0;
    wrap = 1'b0;
    halt = 1'b0;
    unique case (state)
      IDLE: begin
        if (mseq_start && !mseq_stop) begin
          state_nx = RUN;
          go = 1'b1;
        end
      end
      RUN: begin
        if (mseq_stop) begin
          state_nx = IDLE;
        end else if (!reload && (div_cnt == div_q)) begin
          chip = 1'b1;
          wrap = (chip_cnt == LAST);
          halt = wrap && os_q;
          if (halt) begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // LFSR, output word, divider and chip counter datapath.
  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) begin
      lfsr <= '0;
      MSEQ_signal <= '0;
      MSEQ_valid <= 1'b0;
      period_done <= 1'b0;
      div_cnt <= '0;
      div_q <= '0;
      chip_cnt <= '0;
      os_q <= 1'b0;
    end else begin
      MSEQ_valid <= 1'b0;
      period_done <= 1'b0;
      if (go) begin
        lfsr <= seed_eff;
        MSEQ_signal <= seed_eff;
        MSEQ_valid <= 1'b1;
        div_cnt <= '0;
        chip_cnt <= '0;
        div_q <= chip_div;
        os_q <= one_shot;
      end else if (reload) begin
        lfsr <= ONE;
        MSEQ_signal <= ONE;
        MSEQ_valid <= 1'b1;
        div_cnt <= '0;
        chip_cnt <= '0;
      end else if (chip) begin
        div_cnt <= '0;
        period_done <= wrap;
        if (!halt) begin
          lfsr <= lfsr_nx;
          MSEQ_signal <= lfsr_nx;
          MSEQ_valid <= 1'b1;
          chip_cnt <= wrap ? '0 : chip_cnt + ONE;
        end
      end else if (busy && !mseq_stop) begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule
